// File: rtl/score_pkg.sv
// Shared constants and FSM encoding for the BCD score conversion scheduler.
package score_pkg;

  localparam int W      = 32;
  localparam int DIGITS = 8;
  localparam int ACC_W  = 40;

  localparam logic [4*DIGITS-1:0] SAT_BCD = 32'h9999_9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STORE
  } state_t;

endpackage

// File: rtl/bcd_score_sched_dd_engine.sv
// Serial double-dabble engine: one add-3-then-shift step per enabled cycle.
module dd_engine
  import score_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             bit_in,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] adjusted;

  always_comb begin
    adjusted = acc;
    for (int d = 0; d < ACC_W / 4; d++) begin
      if (acc[d*4 +: 4] >= 4'd5) begin
        adjusted[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
      end
    end
  end

  // The top adjusted bit falls off the shift; 40 bits already cover 2^32-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (start) begin
      acc <= '0;
    end else if (step) begin
      acc <= ACC_W'({adjusted, bit_in});
    end
  end

endmodule

// File: rtl/bcd_score_sched.sv
// Round-robin scheduler sharing one double-dabble engine across score requesters.
module bcd_score_sched
  import score_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*W-1:0]        value,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ*4*DIGITS-1:0] bcd,
  output logic [N_REQ-1:0]          valid,
  output logic [N_REQ-1:0]          ovf,
  output logic                      busy
);

  localparam int SLOT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W  = $clog2(W);

  state_t              state;
  state_t              next_state;
  logic [SLOT_W-1:0]   ptr;
  logic [SLOT_W-1:0]   slot;
  logic [SLOT_W-1:0]   grant_slot;
  logic                grant_found;
  logic [N_REQ-1:0]    eligible;
  logic [CNT_W-1:0]    count;
  logic [W-1:0]        src;
  logic                start;
  logic                step;
  logic [ACC_W-1:0]    acc;
  logic [4*DIGITS-1:0] result [N_REQ];

  // A slot being acked this cycle is masked so it cannot be granted twice.
  assign eligible = req & ~ack;

  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_slot  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_slot  = SLOT_W'(idx);
      end
    end
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          next_state = SHIFT;
          start      = 1'b1;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (count == '0) begin
          next_state = STORE;
        end
      end
      STORE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= SLOT_W'(N_REQ - 1);
      slot  <= '0;
      count <= '0;
      src   <= '0;
      busy  <= 1'b0;
      ack   <= '0;
      valid <= '0;
      ovf   <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        result[i] <= '0;
      end
    end else begin
      busy <= (next_state != IDLE);
      ack  <= '0;
      if (start) begin
        src   <= value[int'(grant_slot)*W +: W];
        count <= CNT_W'(W - 1);
        ptr   <= grant_slot;
        slot  <= grant_slot;
      end else if (step) begin
        count <= count - 1'b1;
      end
      // Anything in the upper two digits cannot be shown on eight digits.
      if (state == STORE) begin
        if (acc[ACC_W-1:4*DIGITS] != '0) begin
          result[slot] <= SAT_BCD;
          ovf[slot]    <= 1'b1;
        end else begin
          result[slot] <= acc[4*DIGITS-1:0];
          ovf[slot]    <= 1'b0;
        end
        valid[slot] <= 1'b1;
        ack[slot]   <= 1'b1;
      end
    end
  end

  dd_engine u_engine (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .step   (step),
    .bit_in (src[count]),
    .acc    (acc)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_bcd
    assign bcd[g*4*DIGITS +: 4*DIGITS] = result[g];
  end

endmodule

// File: tb/tb_bcd_score_sched.sv
// Randomized and directed checks of bcd_score_sched against a decimal reference model.
module tb_bcd_score_sched;

  localparam int N      = 3;
  localparam int PERIOD = 34;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*32-1:0] value;
  logic [N-1:0]  ack;
  logic [N*32-1:0] bcd;
  logic [N-1:0]  valid;
  logic [N-1:0]  ovf;
  logic          busy;

  int total = 0;
  int bad = 0;
  int cycleCount = 0;

  logic [31:0] expVal [N];
  logic [31:0] expBcd [N];
  logic        expOvf [N];
  logic        expValid [N];

  int s, t, c0, prev, acks;
  int raiseAt [N];
  logic dropNext [N];
  int seqA [4];
  int seqB [3];

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  bcd_score_sched #(.N_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .value (value),
    .ack   (ack),
    .bcd   (bcd),
    .valid (valid),
    .ovf   (ovf),
    .busy  (busy)
  );

  // Decimal digits from plain division; anything above eight digits saturates.
  function automatic logic [32:0] refConvert(input logic [31:0] v);
    longint unsigned n;
    logic [31:0] d;
    n = 64'(v);
    d = '0;
    if (n > 64'd99999999) return {1'b1, 32'h9999_9999};
    for (int k = 0; k < 8; k++) begin
      d[k*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return {1'b0, d};
  endfunction

  function automatic logic [31:0] randValue();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 9999));
      1:       return $urandom % 32'd100000000;
      2:       return $urandom_range(32'd100000000, 32'hFFFF_FFFF);
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < N; i++) begin
      expBcd[i]   = '0;
      expOvf[i]   = 1'b0;
      expValid[i] = 1'b0;
    end
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    req   = '0;
    value = '0;
    clearModel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic handleAck(input int slot);
    logic [32:0] r;
    r = refConvert(expVal[slot]);
    expBcd[slot]   = r[31:0];
    expOvf[slot]   = r[32];
    expValid[slot] = 1'b1;
    checkOutput($sformatf("ack_onehot_s%0d", slot), 64'(ack), 64'(3'b001 << slot));
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("bcd%0d", i), 64'(bcd[i*32 +: 32]), 64'(expBcd[i]));
      checkOutput($sformatf("ovf%0d", i), 64'(ovf[i]), 64'(expOvf[i]));
      checkOutput($sformatf("valid%0d", i), 64'(valid[i]), 64'(expValid[i]));
    end
  endtask

  task automatic waitAck(input int budget, output int slot, output int when);
    slot = -1;
    when = 0;
    for (int c = 0; c < budget && slot < 0; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        for (int i = N - 1; i >= 0; i--) if (ack[i]) slot = i;
        when = cycleCount;
        handleAck(slot);
      end
    end
    if (slot < 0) checkOutput("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic dropReq(input int slot);
    @(posedge clk);
    #1;
    if (slot >= 0) req[slot] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    value = '0;
    for (int i = 0; i < N; i++) begin
      expVal[i]   = '0;
      raiseAt[i]  = 0;
      dropNext[i] = 1'b0;
    end
    applyReset();

    @(negedge clk);
    checkOutput("rst_ack", 64'(ack), 64'd0);
    checkOutput("rst_valid", 64'(valid), 64'd0);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_bcd", 64'(bcd[63:0]) ^ 64'(bcd[95:64]), 64'd0);

    // Single request on slot 0
    @(posedge clk); #1;
    value[31:0] = 32'd2048; expVal[0] = 32'd2048; req[0] = 1'b1; c0 = cycleCount;
    @(negedge clk);
    checkOutput("t1_busy_idle", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("t1_busy_run", 64'(busy), 64'd1);
    waitAck(40, s, t);
    checkOutput("t1_slot", 64'(s), 64'd0);
    checkOutput("t1_latency", 64'(t - c0), 64'(PERIOD));
    checkOutput("t1_busy_at_ack", 64'(busy), 64'd0);
    checkOutput("t1_bcd", 64'(bcd[31:0]), 64'h2048);
    dropReq(0);
    @(negedge clk);
    checkOutput("t1_ack_pulse", 64'(ack), 64'd0);
    checkOutput("t1_no_regrant", 64'(busy), 64'd0);

    // Three simultaneous requests from reset
    applyReset();
    @(posedge clk); #1;
    value = {32'd131072, 32'd99999999, 32'd0};
    expVal[0] = 32'd0; expVal[1] = 32'd99999999; expVal[2] = 32'd131072;
    req = 3'b111; c0 = cycleCount;
    for (int k = 0; k < 3; k++) begin
      waitAck(120, s, t);
      checkOutput($sformatf("t2_order%0d", k), 64'(s), 64'(k));
      checkOutput($sformatf("t2_time%0d", k), 64'(t - c0), 64'(PERIOD * (k + 1)));
      dropReq(s);
    end
    checkOutput("t2_bcd1", 64'(bcd[63:32]), 64'h9999_9999);
    checkOutput("t2_ovf1", 64'(ovf[1]), 64'd0);
    checkOutput("t2_bcd2", 64'(bcd[95:64]), 64'h0013_1072);

    // Saturation followed by a normal value on the same slot
    value[63:32] = 32'hFFFF_FFFF; expVal[1] = 32'hFFFF_FFFF; req[1] = 1'b1;
    waitAck(80, s, t);
    checkOutput("t3_slot_sat", 64'(s), 64'd1);
    checkOutput("t3_ovf_set", 64'(ovf[1]), 64'd1);
    dropReq(s);
    value[63:32] = 32'd100; expVal[1] = 32'd100; req[1] = 1'b1;
    waitAck(80, s, t);
    checkOutput("t3_bcd_100", 64'(bcd[63:32]), 64'h0000_0100);
    checkOutput("t3_ovf_clr", 64'(ovf[1]), 64'd0);
    dropReq(s);

    // Fairness: slots 0 and 2 held; last served was 1 so slot 2 goes first
    seqA = '{2, 0, 2, 0};
    seqB = '{2, 0, 1};
    value[31:0] = 32'd9; expVal[0] = 32'd9;
    value[95:64] = 32'd1234567; expVal[2] = 32'd1234567;
    req[0] = 1'b1; req[2] = 1'b1; prev = cycleCount;
    for (int k = 0; k < 4; k++) begin
      waitAck(80, s, t);
      checkOutput($sformatf("t4_rr%0d", k), 64'(s), 64'(seqA[k]));
      checkOutput($sformatf("t4_gap%0d", k), 64'(t - prev), 64'(PERIOD));
      prev = t;
    end
    @(posedge clk); #1;
    value[63:32] = 32'd31415926; expVal[1] = 32'd31415926; req[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      waitAck(80, s, t);
      checkOutput($sformatf("t4_late%0d", k), 64'(s), 64'(seqB[k]));
      checkOutput($sformatf("t4_lgap%0d", k), 64'(t - prev), 64'(PERIOD));
      prev = t;
    end
    @(posedge clk); #1;
    req = '0;
    waitAck(80, s, t);
    checkOutput("t4_drain_slot", 64'(s), 64'd2);
    @(negedge clk);
    checkOutput("t4_idle", 64'(busy), 64'd0);

    // Reset in the middle of a conversion
    @(posedge clk); #1;
    value[31:0] = 32'd4321; expVal[0] = 32'd4321; req[0] = 1'b1;
    repeat (16) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    clearModel();
    checkOutput("t5_ack", 64'(ack), 64'd0);
    checkOutput("t5_valid", 64'(valid), 64'd0);
    checkOutput("t5_ovf", 64'(ovf), 64'd0);
    checkOutput("t5_busy", 64'(busy), 64'd0);
    checkOutput("t5_bcd", 64'(bcd[63:0]) | 64'(bcd[95:64]), 64'd0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("t5_hold_ack", 64'(ack), 64'd0);
    end
    rst_n = 1'b1;
    waitAck(40, s, t);
    checkOutput("t5_slot", 64'(s), 64'd0);
    checkOutput("t5_bcd_after", 64'(bcd[31:0]), 64'h0000_4321);
    dropReq(s);

    // Value change and request drop after grant
    value[95:64] = 32'd512; expVal[2] = 32'd512; req[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    value[95:64] = 32'd7; req[2] = 1'b0;
    waitAck(40, s, t);
    checkOutput("t6_slot", 64'(s), 64'd2);
    checkOutput("t6_bcd", 64'(bcd[95:64]), 64'h0000_0512);
    repeat (3) begin
      @(negedge clk);
      checkOutput("t6_no_regrant", 64'({busy, ack}), 64'd0);
    end

    // Randomized requesters that hold req and value until acked
    acks = 0;
    for (int c = 0; c < 5000 && acks < 24; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (dropNext[i]) begin
          req[i] = 1'b0;
          dropNext[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          expVal[i] = randValue();
          value[i*32 +: 32] = expVal[i];
          req[i] = 1'b1;
          raiseAt[i] = cycleCount;
        end
      end
      @(negedge clk);
      if (ack != '0) begin
        s = -1;
        for (int i = N - 1; i >= 0; i--) if (ack[i]) s = i;
        handleAck(s);
        checkOutput("rnd_was_req", 64'(req[s]), 64'd1);
        checkOutput("rnd_wait_bound", 64'(cycleCount - raiseAt[s] <= N * PERIOD), 64'd1);
        dropNext[s] = 1'b1;
        acks++;
      end
    end
    checkOutput("rnd_ack_count", 64'(acks >= 24), 64'd1);

    @(posedge clk); #1;
    req = '0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        s = -1;
        for (int i = N - 1; i >= 0; i--) if (ack[i]) s = i;
        handleAck(s);
      end else if (!busy) begin
        break;
      end
    end
    checkOutput("rnd_final_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
